// File: rtl/axi4_pkg.sv
// axi4_pkg: AXI4 burst/response encodings and FSM state types shared by the burst slave memory.
package axi4_pkg;
  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;
endpackage

// File: rtl/axi4_slv_mem_ram.sv
// axi4_slv_mem_ram: 1W/1R word array with byte enables and a registered read port, no reset.
module axi4_slv_mem_ram #(
  parameter int DW    = 32,
  parameter int DEPTH = 256,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [IW-1:0]   waddr,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wstrb,
  input  logic            re,
  input  logic [IW-1:0]   raddr,
  output logic [DW-1:0]   rdata
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we)
      for (int b = 0; b < DW/8; b++)
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
  end
  // Separate process: a same-cycle write to the read word yields the old contents.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/axi4_burst_slv_mem.sv
// axi4_burst_slv_mem: AXI4 INCR/FIXED burst slave over an internal word-addressed RAM.
// Independent write (IDLE/DATA/RESP) and read (IDLE/DATA) FSMs; out-of-range beats give SLVERR.
module axi4_burst_slv_mem
  import axi4_pkg::*;
#(
  parameter int                              C_S_AXI_DATA_WIDTH = 32,
  parameter int                              C_S_AXI_ADDR_WIDTH = 32,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0]   C_BASE_ADDR        = 32'h80000000,
  parameter int                              C_MEM_DEPTH        = 256
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     AWADDR,
  input  logic [7:0]                        AWLEN,
  input  logic [1:0]                        AWBURST,
  input  logic                              AWVALID,
  output logic                              AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   WSTRB,
  input  logic                              WLAST,
  input  logic                              WVALID,
  output logic                              WREADY,
  output logic [1:0]                        BRESP,
  output logic                              BVALID,
  input  logic                              BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     ARADDR,
  input  logic [7:0]                        ARLEN,
  input  logic [1:0]                        ARBURST,
  input  logic                              ARVALID,
  output logic                              ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     RDATA,
  output logic [1:0]                        RRESP,
  output logic                              RLAST,
  output logic                              RVALID,
  input  logic                              RREADY
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int SH = $clog2(DW/8);
  localparam int IW = $clog2(C_MEM_DEPTH);
  localparam logic [AW-1:0] STEP = AW'(DW/8);

  // Index is computed at full address width so an INCR burst past the top never wraps.
  function automatic logic in_rng(input logic [AW-1:0] a);
    return (a >= C_BASE_ADDR) && (((a - C_BASE_ADDR) >> SH) < AW'(C_MEM_DEPTH));
  endfunction

  function automatic logic [IW-1:0] idx(input logic [AW-1:0] a);
    return IW'((a - C_BASE_ADDR) >> SH);
  endfunction

  wstate_t       wstate_q, wstate_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [7:0]    wlen_q, wlen_d;
  logic [1:0]    wburst_q, wburst_d;
  logic [8:0]    wbeat_q, wbeat_d;
  logic          werr_q, werr_d;
  logic          awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  resp_t         bresp_q, bresp_d;
  logic          mem_we, w_hit;

  rstate_t       rstate_q, rstate_d;
  logic [AW-1:0] raddr_q, raddr_d, r_next, rd_addr;
  logic [7:0]    rlen_q, rlen_d;
  logic [1:0]    rburst_q, rburst_d;
  logic [8:0]    rbeat_q, rbeat_d;
  logic          rvalid_q, rvalid_d, rlast_q, rlast_d, rerr_q, rerr_d;
  logic          arready_q, arready_d, mem_re;
  logic [DW-1:0] ram_rdata;

  always_comb begin
    wstate_d = wstate_q;
    waddr_d  = waddr_q;
    wlen_d   = wlen_q;
    wburst_d = wburst_q;
    wbeat_d  = wbeat_q;
    werr_d   = werr_q;
    mem_we   = 1'b0;
    w_hit    = wbeat_q <= {1'b0, wlen_q};
    if (wstate_q == W_IDLE && AWVALID && awready_q) begin
      wstate_d = W_DATA;
      waddr_d  = AWADDR;
      wlen_d   = AWLEN;
      wburst_d = AWBURST;
      wbeat_d  = '0;
      werr_d   = AWBURST == BURST_WRAP;
    end else if (wstate_q == W_DATA && WVALID && wready_q) begin
      // Beats past AWLEN are swallowed: no write, no advance, only WLAST ends the burst.
      mem_we   = w_hit && in_rng(waddr_q) && wburst_q != BURST_WRAP;
      werr_d   = werr_q || (w_hit && !in_rng(waddr_q)) || (WLAST && wbeat_q != {1'b0, wlen_q});
      wbeat_d  = w_hit ? wbeat_q + 9'd1 : wbeat_q;
      waddr_d  = (w_hit && wburst_q == BURST_INCR) ? waddr_q + STEP : waddr_q;
      wstate_d = WLAST ? W_RESP : W_DATA;
    end else if (wstate_q == W_RESP && BREADY && bvalid_q) begin
      wstate_d = W_IDLE;
    end
    awready_d = wstate_d == W_IDLE;
    wready_d  = wstate_d == W_DATA;
    bvalid_d  = wstate_d == W_RESP;
    bresp_d   = (wstate_d == W_RESP && werr_d) ? RESP_SLVERR : RESP_OKAY;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wstate_q  <= W_IDLE;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wburst_q  <= '0;
      wbeat_q   <= '0;
      werr_q    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      wstate_q  <= wstate_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wburst_q  <= wburst_d;
      wbeat_q   <= wbeat_d;
      werr_q    <= werr_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // The RAM is read only when a new beat is launched, so its output holds through stalls.
  always_comb begin
    rstate_d  = rstate_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rburst_d  = rburst_q;
    rbeat_d   = rbeat_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rerr_d    = rerr_q;
    mem_re    = 1'b0;
    r_next    = rburst_q == BURST_INCR ? raddr_q + STEP : raddr_q;
    rd_addr   = r_next;
    if (rstate_q == R_IDLE && ARVALID && arready_q) begin
      rstate_d = R_DATA;
      raddr_d  = ARADDR;
      rlen_d   = ARLEN;
      rburst_d = ARBURST;
      rbeat_d  = '0;
      rd_addr  = ARADDR;
      mem_re   = 1'b1;
      rvalid_d = 1'b1;
      rlast_d  = ARLEN == 8'd0;
      rerr_d   = !in_rng(ARADDR) || ARBURST == BURST_WRAP;
    end else if (rstate_q == R_DATA && rvalid_q && RREADY) begin
      if (rlast_q) begin
        rstate_d = R_IDLE;
        rvalid_d = 1'b0;
        rlast_d  = 1'b0;
        rerr_d   = 1'b0;
      end else begin
        raddr_d  = r_next;
        rbeat_d  = rbeat_q + 9'd1;
        mem_re   = 1'b1;
        rlast_d  = rbeat_q + 9'd1 == {1'b0, rlen_q};
        rerr_d   = !in_rng(r_next) || rburst_q == BURST_WRAP;
      end
    end
    arready_d = rstate_d == R_IDLE;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rstate_q  <= R_IDLE;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rburst_q  <= '0;
      rbeat_q   <= '0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rerr_q    <= 1'b0;
      arready_q <= 1'b0;
    end else begin
      rstate_q  <= rstate_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rburst_q  <= rburst_d;
      rbeat_q   <= rbeat_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rerr_q    <= rerr_d;
      arready_q <= arready_d;
    end
  end

  axi4_slv_mem_ram #(.DW(DW), .DEPTH(C_MEM_DEPTH), .IW(IW)) u_ram (
    .clk   (ACLK),
    .we    (mem_we),
    .waddr (idx(waddr_q)),
    .wdata (WDATA),
    .wstrb (WSTRB),
    .re    (mem_re),
    .raddr (idx(rd_addr)),
    .rdata (ram_rdata)
  );

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RLAST   = rlast_q;
  assign RDATA   = (rvalid_q && !rerr_q) ? ram_rdata : '0;
  assign RRESP   = (rvalid_q && rerr_q) ? RESP_SLVERR : RESP_OKAY;
endmodule
